// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register bank: clear-engine state
// encoding, the byte-strobe merge helper and the parameter limits that the
// top level checks at elaboration.
package rf_pkg;

  // States of the sequential bulk-clear engine.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_t;

  // Parameter limits checked when the bank is elaborated.
  localparam int RF_BYTE_W    = 8;
  localparam int RF_MIN_DEPTH = 2;
  localparam int RF_MIN_RD    = 1;
  localparam int RF_MAX_RD    = 8;

  // Byte merge for one lane: the new byte where its strobe is set, else the old byte.
  function automatic logic [RF_BYTE_W-1:0] byte_merge(
    input logic [RF_BYTE_W-1:0] old_byte,
    input logic [RF_BYTE_W-1:0] new_byte,
    input logic                 strb
  );
    return strb ? new_byte : old_byte;
  endfunction

  // True when n is a positive power of two.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/rf_clear_ctrl.sv
// Bulk-clear sequencer for register_bank_mp. It walks a pointer over every
// entry, asserting a clear-write for one entry per cycle, then spends one
// cycle in DONE to pulse clr_done. clr_busy and clr_done are registered.
module rf_clear_ctrl
  import rf_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clear_we,
  output logic [AW-1:0] clear_addr,
  output logic          idle
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  clr_state_t    state;
  logic [AW-1:0] ptr;

  // FSM, clear pointer and registered status outputs.
  // NOTE: every register here is assigned with <= so that all of them
  // update from the same pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            ptr      <= '0;
            clr_busy <= 1'b1;
          end
        end
        CLEAR: begin
          if (ptr == LAST) begin
            state    <= DONE;
            clr_done <= 1'b1;
          end else begin
            ptr <= ptr + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          clr_busy <= 1'b0;
          clr_done <= 1'b0;
        end
      endcase
    end
  end

  // Decoded controls: one entry cleared per CLEAR cycle; external writes only in IDLE.
  assign clear_we   = (state == CLEAR);
  assign clear_addr = ptr;
  assign idle       = (state == IDLE);

endmodule

// File: rtl/register_bank_mp.sv
// Multi-port register bank: byte-strobed single write port, NUM_RD
// combinational read ports, optional hard-wired zero register and a
// sequential bulk-clear engine (rf_clear_ctrl).
// Optional feature macro: RF_BYPASS_EN -- when defined, a read of the
// address being written in the same cycle returns the strobe-merged value.
module register_bank_mp
  import rf_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 8,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [WIDTH/8-1:0]      wstrb,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0] raddr,
  output logic [NUM_RD*WIDTH-1:0] rdata,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic                    clr_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int NB = WIDTH / 8;

  // Elaboration-time parameter checks.
  if ((WIDTH % RF_BYTE_W) != 0 || WIDTH < RF_BYTE_W) begin : g_bad_width
    $error("register_bank_mp: WIDTH must be a positive multiple of 8");
  end
  if (!is_pow2(DEPTH) || DEPTH < RF_MIN_DEPTH) begin : g_bad_depth
    $error("register_bank_mp: DEPTH must be a power of two and at least 2");
  end
  if (NUM_RD < RF_MIN_RD || NUM_RD > RF_MAX_RD) begin : g_bad_num_rd
    $error("register_bank_mp: NUM_RD must be in 1..8");
  end
  if (ZERO_REG != 0 && ZERO_REG != 1) begin : g_bad_zero_reg
    $error("register_bank_mp: ZERO_REG must be 0 or 1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] wmerged;
  logic             write_en;
  logic             clear_we;
  logic [AW-1:0]    clear_addr;
  logic             idle;

  rf_clear_ctrl #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_clear_ctrl (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .idle       (idle)
  );

  // External writes commit only in IDLE and never to a masked zero register.
  assign write_en = we && idle && !((ZERO_REG != 0) && (waddr == '0));

  // Strobe-merge of the addressed entry with the incoming write data.
  always_comb begin
    wmerged = mem[waddr];
    for (int b = 0; b < NB; b++) begin
      wmerged[b*8 +: 8] = byte_merge(mem[waddr][b*8 +: 8], wdata[b*8 +: 8], wstrb[b]);
    end
  end

  // Storage array: clear-engine writes and strobed external writes.
  // NOTE: the array carries the async reset on purpose -- reset must read
  // back as all zeros, which rules out a plain RAM macro without reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) begin
        mem[k] <= '0;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (clear_we && clear_addr == AW'(k)) begin
          mem[k] <= '0;
        end else if (write_en && waddr == AW'(k)) begin
          mem[k] <= wmerged;
        end
      end
    end
  end

  // Independent combinational read ports with optional same-cycle bypass.
  // NOTE: rdata gets a full default before the loop so no path through
  // this block leaves a bit unassigned, which would infer a latch.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rdata[i*WIDTH +: WIDTH] = mem[raddr[i*AW +: AW]];
`ifdef RF_BYPASS_EN
      if (write_en && waddr == raddr[i*AW +: AW]) begin
        rdata[i*WIDTH +: WIDTH] = wmerged;
      end
`else
`endif
      if ((ZERO_REG != 0) && raddr[i*AW +: AW] == '0) begin
        rdata[i*WIDTH +: WIDTH] = '0;
      end
    end
  end

endmodule

// File: tb/tb_register_bank_mp.sv
// Self-checking bench for register_bank_mp. Two instances (ZERO_REG=0 and
// ZERO_REG=1) share all stimulus. A behavioural model of the register
// contents and clear sequence is compared on every falling edge; directed
// sections add hand-computed literal expectations.
module tb_register_bank_mp;

  localparam int WIDTH  = 16;
  localparam int DEPTH  = 8;
  localparam int NUM_RD = 3;
  localparam int AW     = 3;
  localparam int NB     = 2;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    we;
  logic [AW-1:0]           waddr;
  logic [WIDTH-1:0]        wdata;
  logic [NB-1:0]           wstrb;
  logic [NUM_RD*AW-1:0]    raddr;
  logic                    clr_req;
  logic [NUM_RD*WIDTH-1:0] rdata0, rdata1;
  logic                    busy0, done0, busy1, done1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  register_bank_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr(raddr), .rdata(rdata0), .clr_req(clr_req), .clr_busy(busy0), .clr_done(done0)
  );

  register_bank_mp #(.WIDTH(WIDTH), .DEPTH(DEPTH), .NUM_RD(NUM_RD), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
    .raddr(raddr), .rdata(rdata1), .clr_req(clr_req), .clr_busy(busy1), .clr_done(done1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_active = 1'b0;   // a clear sequence is in progress
  int               m_idx    = 0;      // next entry to clear; DEPTH = finishing
  bit               cmp_en   = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) m_mem[k] = '0;
      m_active = 1'b0;
      m_idx    = 0;
    end else if (!m_active) begin
      if (we) begin
        for (int b = 0; b < NB; b++)
          if (wstrb[b]) m_mem[waddr][b*8 +: 8] = wdata[b*8 +: 8];
      end
      if (clr_req) begin
        m_active = 1'b1;
        m_idx    = 0;
      end
    end else if (m_idx < DEPTH) begin
      m_mem[m_idx] = '0;
      m_idx++;
    end else begin
      m_active = 1'b0;
    end
  end

  function automatic logic [WIDTH-1:0] exp_read(input int a, input bit zero_reg);
    logic [WIDTH-1:0] v;
    v = m_mem[a];
`ifdef RF_BYPASS_EN
    if (we && !m_active && a == int'(waddr))
      for (int b = 0; b < NB; b++)
        if (wstrb[b]) v[b*8 +: 8] = wdata[b*8 +: 8];
`endif
    if (zero_reg && a == 0) v = '0;
    return v;
  endfunction

  // Compare process: every falling edge while enabled.
  always @(negedge clk) begin
    if (cmp_en) begin
      for (int i = 0; i < NUM_RD; i++) begin
        check($sformatf("model_rd0_p%0d", i), 32'(rdata0[i*WIDTH +: WIDTH]),
              32'(exp_read(int'(raddr[i*AW +: AW]), 1'b0)));
        check($sformatf("model_rd1_p%0d", i), 32'(rdata1[i*WIDTH +: WIDTH]),
              32'(exp_read(int'(raddr[i*AW +: AW]), 1'b1)));
      end
      check("model_busy", 32'({busy1, busy0}), 32'({2{m_active}}));
      check("model_done", 32'({done1, done0}), 32'({2{m_active && m_idx == DEPTH}}));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_raddr(input int a0, input int a1, input int a2);
    raddr = {AW'(a2), AW'(a1), AW'(a0)};
  endtask

  task automatic do_write(input int a, input logic [WIDTH-1:0] d, input logic [NB-1:0] s);
    we = 1'b1; waddr = AW'(a); wdata = d; wstrb = s;
    tick();
    we = 1'b0; wstrb = '0;
  endtask

  function automatic logic [WIDTH-1:0] rd0(input int p);
    return rdata0[p*WIDTH +: WIDTH];
  endfunction

  function automatic logic [WIDTH-1:0] rd1(input int p);
    return rdata1[p*WIDTH +: WIDTH];
  endfunction

  task automatic fill();
    for (int i = 0; i < DEPTH; i++) do_write(i, WIDTH'(16'h1111 * i), 2'b11);
  endtask

  // Starts a clear and counts busy/done cycles over a bounded window.
  // With mid_writes set, writes to reg 5 are attempted in clear cycles 3 and 7.
  task automatic run_clear(input bit mid_writes, output int nb, output int nd);
    nb = 0; nd = 0;
    set_raddr(7, 5, 0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int c = 0; c < 20; c++) begin
      we = mid_writes && (c == 3 || c == 7);
      waddr = 3'd5; wdata = 16'hABCD; wstrb = 2'b11;
      @(negedge clk);
      if (busy0) nb++;
      if (done0) nd++;
      if (mid_writes && c == 4) check("clr_reg5_before_slot", 32'(rd0(1)), 32'h5555);
      if (mid_writes && c == 6) check("clr_reg5_after_slot", 32'(rd0(1)), 32'h0000);
      tick();
    end
    we = 1'b0; wstrb = '0;
  endtask

  initial begin
    int nb, nd;
    rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0; wstrb = '0;
    clr_req = 1'b0; raddr = '0;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    rst_n  = 1'b1;

    // Reset state on every address across three ports.
    for (int a = 0; a < DEPTH; a++) begin
      set_raddr(a, (a + 1) % DEPTH, (a + 5) % DEPTH);
      @(negedge clk);
      for (int p = 0; p < NUM_RD; p++) check("reset_read", 32'(rd0(p)), 32'h0);
      tick();
    end
    check("reset_busy", 32'(busy0), 32'h0);
    check("reset_done", 32'(done0), 32'h0);

    // Byte-strobed writes.
    do_write(3, 16'hA5C3, 2'b11);
    do_write(3, 16'h7E00, 2'b10);
    set_raddr(3, 3, 3);
    @(negedge clk);
    for (int p = 0; p < NUM_RD; p++) check("strobe_merge", 32'(rd0(p)), 32'h7EC3);
    tick();
    do_write(3, 16'hFFFF, 2'b00);
    @(negedge clk);
    check("strobe_none", 32'(rd0(0)), 32'h7EC3);
    tick();

    // Zero register.
    do_write(0, 16'hFFFF, 2'b11);
    do_write(1, 16'h1234, 2'b11);
    set_raddr(0, 1, 0);
    @(negedge clk);
    check("zero_reg_p0", 32'(rd1(0)), 32'h0);
    check("zero_reg_p2", 32'(rd1(2)), 32'h0);
    check("zero_reg_reg1", 32'(rd1(1)), 32'h1234);
    check("nozero_reg0", 32'(rd0(0)), 32'hFFFF);
    tick();

    // Write-to-read bypass on port 1.
    fill();
    set_raddr(0, 2, 4);
    we = 1'b1; waddr = 3'd2; wdata = 16'hBEEF; wstrb = 2'b11;
    @(negedge clk);
`ifdef RF_BYPASS_EN
    check("bypass_same_cycle", 32'(rd0(1)), 32'hBEEF);
`else
    check("bypass_same_cycle", 32'(rd0(1)), 32'h2222);
`endif
    tick();
    we = 1'b0; wstrb = '0;
    @(negedge clk);
    check("bypass_next_cycle", 32'(rd0(1)), 32'hBEEF);
    tick();

    // Bulk clear with dropped mid-clear writes.
    fill();
    run_clear(1'b1, nb, nd);
    check("clear_busy_cycles", 32'(nb), 32'd9);
    check("clear_done_pulses", 32'(nd), 32'd1);
    set_raddr(5, 7, 0);
    @(negedge clk);
    check("clear_reg5_dropped", 32'(rd0(0)), 32'h0);
    check("clear_reg7", 32'(rd0(1)), 32'h0);
    tick();

    // Reset in the middle of a clear (pointer at 4).
    fill();
    set_raddr(3, 4, 6);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    repeat (4) tick();
    check("midclr_reg3_cleared", 32'(rd0(0)), 32'h0);
    check("midclr_reg4_pending", 32'(rd0(1)), 32'h4444);
    rst_n = 1'b0;
    #1;
    check("midclr_rst_reg4", 32'(rd0(1)), 32'h0);
    check("midclr_rst_reg6", 32'(rd0(2)), 32'h0);
    check("midclr_rst_busy", 32'(busy0), 32'h0);
    nd = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done0 || done1) nd++;
      tick();
      if (c == 2) rst_n = 1'b1;
    end
    check("midclr_no_done", 32'(nd), 32'd0);
    check("midclr_idle", 32'(busy0), 32'h0);

    // A fresh clear after reset completes normally.
    fill();
    run_clear(1'b0, nb, nd);
    check("reclear_busy_cycles", 32'(nb), 32'd9);
    check("reclear_done_pulses", 32'(nd), 32'd1);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/register_bank_mp.md
# register_bank_mp

Parametrised multi-port register bank; successor to the two-port, full-word register bank. Adds a configurable read-port count, byte-strobed writes, an optional hard-wired zero register and a sequential bulk-clear engine. Optional write-to-read bypass is compiled in by macro. Sits under `top` as the datapath register file for small cores and test fixtures.

## Interface
- WIDTH, 16: data width in bits; multiple of 8.
- DEPTH, 8: number of registers; power of two, ≥2.
- NUM_RD, 2: number of read ports, 1..8.
- ZERO_REG, 0: 1 = register 0 always reads 0 and ignores writes.
- AW (localparam): $clog2(DEPTH). NB (localparam): WIDTH/8.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- waddr  in  AW  write address.
- wdata  in  WIDTH  write data.
- wstrb  in  NB  byte enables; bit b covers wdata[8b+7:8b].
- raddr  in  NUM_RD*AW  read addresses; port i at [i*AW +: AW].
- rdata  out  NUM_RD*WIDTH  read data; port i at [i*WIDTH +: WIDTH].
- clr_req  in  1  start bulk clear (level sampled in IDLE).
- clr_busy  out  1  clear engine active.
- clr_done  out  1  one-cycle pulse when clear completes.

## Operation
- Reset: all registers 0, FSM IDLE, clr_busy=0, clr_done=0; rdata therefore 0 on all ports.
- Write: at rising edge with we=1 in IDLE, each byte with wstrb[b]=1 is updated; other bytes hold. wstrb=0 is a no-op.
- ZERO_REG=1: writes to address 0 discarded; reads of address 0 return 0 on every port.
- Read: asynchronous, combinational from raddr; all ports independent; multiple ports may read the same address.
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE → CLEAR when clr_req=1 at an edge; pointer loads 0.
  - CLEAR: each cycle writes 0 to register[ptr], ptr increments; after ptr=DEPTH-1 is cleared → DONE.
  - DONE: clr_done=1 for exactly one cycle → IDLE.
- clr_busy=1 in CLEAR and DONE.
- External writes while clr_busy=1 are dropped (not queued).
- clr_req while busy is ignored; clr_req held high after DONE restarts a clear from IDLE on the next edge.
- clr_req and we together in IDLE: write commits that edge, clear begins the next cycle and overwrites it.
- Reads during CLEAR return current contents: already-cleared entries 0, others old values.
- Reset mid-clear: immediate return to IDLE, all registers 0, no clr_done pulse.

## Timing
- Write latency: data visible on rdata in the cycle after the write edge (without bypass).
- Clear duration: clr_busy rises one cycle after the clr_req edge, lasts DEPTH+1 cycles (DEPTH clearing + 1 DONE).
- clr_done rises in the cycle after register DEPTH-1 is cleared.
- No read latency: rdata settles combinationally within the cycle.

## Configuration
- RF_BYPASS_EN defined: if we=1, FSM in IDLE, waddr==raddr_i, and the address is not zero-register-masked, rdata_i returns the strobe-merged value (stored bytes where wstrb=0, wdata where wstrb=1) in the same cycle.
- RF_BYPASS_EN undefined: rdata_i returns stored contents only; the new value appears the cycle after the write edge.

## Structure
- Package rf_pkg: clear-state enum (IDLE, CLEAR, DONE), byte-merge function (old, new, strb), width-check constants.
- Sub-module rf_clear_ctrl: FSM, pointer, clr_busy/clr_done, clear-write address and enable. The storage array, write merge and read muxes stay in register_bank_mp.
- Parameter checks (WIDTH%8, DEPTH power of two, NUM_RD range) are elaboration-time assertions.

## Test plan
(WIDTH=16, DEPTH=8, NUM_RD=3 unless noted)
- Reset, then read all addresses on 3 ports → every rdata 0000; clr_busy=0, clr_done=0.
- Write 0xA5C3 strb=11 to reg 3, then 0x7E00 strb=10 to reg 3; read reg 3 on all ports → 0x7EC3; strb=00 write → value unchanged.
- ZERO_REG=1: write 0xFFFF to reg 0 → reads 0000; reg 1 unaffected.
- Fill regs with 0x1111*i, pulse clr_req → clr_busy high 9 cycles, reg k reads 0 from the cycle after its clear slot, single clr_done pulse; a write to reg 5 in the middle of the clear is dropped (reads 0).
- RF_BYPASS_EN: write 0xBEEF to reg 2 while port 1 reads 2 → rdata1=0xBEEF in the same cycle. Without the macro → old value, then 0xBEEF the next cycle.
- Assert rst_n low at CLEAR ptr=4 → all registers 0, FSM IDLE, no clr_done; a new clr_req after release completes normally.
